// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter (core MEM stage vs debug port).
package dmem_arb_pkg;

  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int MAX_AW     = 32;
  localparam int STARVE_W   = 4;
  localparam int LOCK_CNT_W = 8;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  typedef enum logic {
    S_NORM = 1'b0,
    S_LOCK = 1'b1
  } arb_state_t;

  // Address is carried at the widest supported width and narrowed at the memory port.
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [MAX_AW-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, debug and memory-side signals of the data-memory arbiter, bundled for port hookup.
interface dmem_arbiter_if #(
  parameter int AW = 10
);
  logic          core_req;
  logic          core_we;
  logic [3:0]    core_be;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
  logic [31:0]   core_rdata;
  logic          core_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [3:0]    dbg_be;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Environment side: requesters and the memory itself.
  modport master (
    output core_req, core_we, core_be, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating debug-starvation counter: counts denied debug cycles, clears on grant or idle.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != STARVE_W'(LIMIT))) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core priority, starvation escape and lockable debug RMW.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input  logic         clock,
  input  logic         reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]  perf_core_stall_cnt,
  output logic [31:0]  perf_dbg_grant_cnt,
  output logic [15:0]  perf_forced_release_cnt
`endif
);

  arb_state_t            state_p0, state_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt_p0;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  starved, lock_expired;
  logic                  core_gnt, dbg_gnt;
  logic                  rd_pend_p0, rd_owner_p0;
  logic [DATA_W-1:0]     core_rdata_p0, dbg_rdata_p0;
  logic                  core_rvalid, dbg_rvalid;
  mem_req_t              core_r, dbg_r, sel_r;

  assign starved      = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign lock_expired = (lock_cnt_p0 == LOCK_CNT_W'(LOCK_MAX - 1));

  dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock (clock),
    .reset (reset),
    .inc   (bus.dbg_req & ~dbg_gnt),
    .clr   (dbg_gnt | ~bus.dbg_req),
    .cnt   (starve_cnt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_p0    <= S_NORM;
      lock_cnt_p0 <= '0;
    end else begin
      state_p0    <= state_nxt;
      lock_cnt_p0 <= (state_p0 == S_LOCK) ? lock_cnt_p0 + LOCK_CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      S_NORM: if (dbg_gnt && bus.dbg_lock) state_nxt = S_LOCK;
      S_LOCK: if (lock_expired || (dbg_gnt && !bus.dbg_lock) ||
                  (!bus.dbg_req && !bus.dbg_lock)) state_nxt = S_NORM;
      default: state_nxt = S_NORM;
    endcase
  end

  // In the forced-release cycle the core overrides a still-requesting debug port.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (reset) begin
      case (state_p0)
        S_NORM: begin
          if (bus.dbg_req && starved) dbg_gnt  = 1'b1;
          else if (bus.core_req)      core_gnt = 1'b1;
          else if (bus.dbg_req)       dbg_gnt  = 1'b1;
        end
        S_LOCK: begin
          if (lock_expired) begin
            if (bus.core_req)      core_gnt = 1'b1;
            else if (bus.dbg_req)  dbg_gnt  = 1'b1;
          end else begin
            if (bus.dbg_req)       dbg_gnt  = 1'b1;
            else if (bus.core_req) core_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_r = '{we: bus.core_we, be: bus.core_be,
                    addr: MAX_AW'(bus.core_addr), wdata: bus.core_wdata};
  assign dbg_r  = '{we: bus.dbg_we, be: bus.dbg_be,
                    addr: MAX_AW'(bus.dbg_addr), wdata: bus.dbg_wdata};
  assign sel_r  = dbg_gnt ? dbg_r : core_r;

  assign bus.core_gnt   = core_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.core_stall = reset & bus.core_req & ~core_gnt;
  assign bus.mem_en     = core_gnt | dbg_gnt;
  assign bus.mem_we     = (core_gnt | dbg_gnt) & sel_r.we;
  assign bus.mem_be     = sel_r.be;
  assign bus.mem_addr   = AW'(sel_r.addr);
  assign bus.mem_wdata  = sel_r.wdata;

  // Read return stage: one cycle behind the grant, matching the memory's registered output.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_pend_p0    <= 1'b0;
      rd_owner_p0   <= OWN_CORE;
      core_rdata_p0 <= '0;
      dbg_rdata_p0  <= '0;
    end else begin
      rd_pend_p0  <= (core_gnt & ~bus.core_we) | (dbg_gnt & ~bus.dbg_we);
      rd_owner_p0 <= dbg_gnt ? OWN_DBG : OWN_CORE;
      if (core_rvalid) core_rdata_p0 <= bus.mem_rdata;
      if (dbg_rvalid)  dbg_rdata_p0  <= bus.mem_rdata;
    end
  end

  assign core_rvalid     = reset & rd_pend_p0 & (rd_owner_p0 == OWN_CORE);
  assign dbg_rvalid      = reset & rd_pend_p0 & (rd_owner_p0 == OWN_DBG);
  assign bus.core_rvalid = core_rvalid;
  assign bus.dbg_rvalid  = dbg_rvalid;
  assign bus.core_rdata  = core_rvalid ? bus.mem_rdata : core_rdata_p0;
  assign bus.dbg_rdata   = dbg_rvalid  ? bus.mem_rdata : dbg_rdata_p0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_core_stall_cnt     <= '0;
      perf_dbg_grant_cnt      <= '0;
      perf_forced_release_cnt <= '0;
    end else begin
      if (bus.core_req && !core_gnt) perf_core_stall_cnt <= perf_core_stall_cnt + 32'd1;
      if (dbg_gnt)                   perf_dbg_grant_cnt  <= perf_dbg_grant_cnt + 32'd1;
      if ((state_p0 == S_LOCK) && lock_expired)
        perf_forced_release_cnt <= perf_forced_release_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int SL = 4;
  localparam int LM = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.AW(AW)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_core_stall_cnt, perf_dbg_grant_cnt;
  logic [15:0] perf_forced_release_cnt;
`endif

  dmem_arbiter #(.AW(AW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_core_stall_cnt     (perf_core_stall_cnt),
    .perf_dbg_grant_cnt      (perf_dbg_grant_cnt),
    .perf_forced_release_cnt (perf_forced_release_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory behind the arbiter: registered read, byte-lane writes.
  logic [31:0] mem [256] = '{default: 32'h0};
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  // Reference model state, kept in plain integers and flags.
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int          m_starve = 0, m_lockc = 0, m_stall = 0, m_dgnt = 0, m_forced = 0;
  bit          m_lock = 0, exp_pend = 0, exp_own = 0;
  logic [31:0] exp_data = '0, hold_c = '0, hold_d = '0;

  // 0 = nobody, 1 = core, 2 = debug
  function automatic int model_win();
    if (!reset) return 0;
    if (!m_lock) begin
      if (bus.dbg_req && m_starve >= SL) return 2;
      if (bus.core_req) return 1;
      if (bus.dbg_req) return 2;
      return 0;
    end
    if (m_lockc == LM - 1) begin
      if (bus.core_req) return 1;
      if (bus.dbg_req) return 2;
      return 0;
    end
    if (bus.dbg_req) return 2;
    if (bus.core_req) return 1;
    return 0;
  endfunction

  function automatic logic [69:0] model_outs();
    int w = model_win();
    bit crv = reset && exp_pend && !exp_own;
    bit drv = reset && exp_pend && exp_own;
    return {(w == 1), (w == 2), (reset && bus.core_req && (w != 1)), (w != 0),
            crv, drv, (crv ? exp_data : hold_c), (drv ? exp_data : hold_d)};
  endfunction

  always @(posedge clock) begin
    if (model_win() == 1 && bus.core_we)
      for (int b = 0; b < 4; b++)
        if (bus.core_be[b]) ref_mem[bus.core_addr[9:2]][8*b +: 8] <= bus.core_wdata[8*b +: 8];
    if (model_win() == 2 && bus.dbg_we)
      for (int b = 0; b < 4; b++)
        if (bus.dbg_be[b]) ref_mem[bus.dbg_addr[9:2]][8*b +: 8] <= bus.dbg_wdata[8*b +: 8];
    if (!reset) begin
      m_starve <= 0; m_lock <= 0; m_lockc <= 0;
      exp_pend <= 0; exp_own <= 0; hold_c <= '0; hold_d <= '0;
      m_stall <= 0; m_dgnt <= 0; m_forced <= 0;
    end else begin
      exp_pend <= (model_win() == 1 && !bus.core_we) || (model_win() == 2 && !bus.dbg_we);
      exp_own  <= (model_win() == 2);
      exp_data <= (model_win() == 2) ? ref_mem[bus.dbg_addr[9:2]] : ref_mem[bus.core_addr[9:2]];
      if (exp_pend && !exp_own) hold_c <= exp_data;
      if (exp_pend && exp_own)  hold_d <= exp_data;
      if (bus.dbg_req && model_win() != 2) m_starve <= (m_starve + 1 > SL) ? SL : m_starve + 1;
      else m_starve <= 0;
      m_stall <= m_stall + ((bus.core_req && model_win() != 1) ? 1 : 0);
      m_dgnt  <= m_dgnt + ((model_win() == 2) ? 1 : 0);
      if (!m_lock) begin
        if (model_win() == 2 && bus.dbg_lock) begin m_lock <= 1; m_lockc <= 0; end
      end else begin
        if (m_lockc == LM - 1) begin
          m_lock <= 0; m_forced <= m_forced + 1;
        end else if ((model_win() == 2 && !bus.dbg_lock) || (!bus.dbg_req && !bus.dbg_lock)) begin
          m_lock <= 0;
        end
        m_lockc <= m_lockc + 1;
      end
    end
  end

  task automatic drive(input logic cr, cw, input logic [3:0] cbe, input logic [9:0] ca,
                       input logic [31:0] cd, input logic dr, dw, input logic [3:0] dbe,
                       input logic [9:0] da, input logic [31:0] dd, input logic dl);
    bus.core_req = cr; bus.core_we = cw; bus.core_be = cbe; bus.core_addr = ca; bus.core_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_be = dbe; bus.dbg_addr = da; bus.dbg_wdata = dd;
    bus.dbg_lock = dl;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 10'h0, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
  endtask

  task automatic sample(output logic [69:0] got, output logic [69:0] want);
    @(negedge clock);
    got  = {bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.mem_en, bus.core_rvalid,
            bus.dbg_rvalid, bus.core_rdata, bus.dbg_rdata};
    want = model_outs();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [69:0] got, want;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'hF, 10'h10, $urandom, 1, 0, 4'hF, 10'h20, $urandom, 1);
      sample(got, want);
      n_checks++;
      if (got !== 70'h0) begin
        n_fail++; $display("FAIL reset[%0d]: got %h required 0", i, got);
      end
      adv();
    end
    reset = 1'b1;
    idle();
    adv();
  endtask

  task automatic test_core_only();
    logic [69:0] got, want;
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      drive(1, 1, 4'hF, 10'd100, 32'h00FF01FF, 0, 0, 4'h0, 10'h0, 32'h0, 0);
      else if (i == 1) drive(1, 0, 4'hF, 10'd100, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0, 0);
      else             idle();
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL core_only[%0d]: got %h model %h", i, got, want); end
      n_checks++;
      if (i < 2 && {bus.core_gnt, bus.core_stall} !== 2'b10) begin
        n_fail++; $display("FAIL core_only_gnt[%0d]: gnt/stall %b required 10", i, {bus.core_gnt, bus.core_stall});
      end else if (i == 2 && {bus.core_rvalid, bus.core_rdata} !== {1'b1, 32'h00FF01FF}) begin
        n_fail++; $display("FAIL core_only_rd: rvalid/rdata %b/%h required 1/00ff01ff", bus.core_rvalid, bus.core_rdata);
      end
      adv();
    end
  endtask

  task automatic test_contention();
    logic [69:0] got, want;
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 0, 4'hF, 10'd0, 32'h0, i < 5, 0, 4'hF, 10'd40, 32'h0, 0);
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL contention[%0d]: got %h model %h", i, got, want); end
      n_checks++;
      if (i < 5 && {bus.dbg_gnt, bus.core_stall} !== {2{i == 4}}) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: dbg_gnt/stall %b required %b", i, {bus.dbg_gnt, bus.core_stall}, {2{i == 4}});
      end else if (i == 5 && bus.dbg_rvalid !== 1'b1) begin
        n_fail++; $display("FAIL contention_rvalid: dbg_rvalid %b required 1", bus.dbg_rvalid);
      end
      adv();
    end
  endtask

  task automatic test_lock_rmw();
    logic [69:0] got, want;
    for (int i = 0; i < 8; i++) begin
      if (i <= 4)      drive(1, 0, 4'hF, 10'd0, 32'h0, 1, 0, 4'hF, 10'd40, 32'h0, 1);
      else if (i == 5) drive(1, 0, 4'hF, 10'd0, 32'h0, 1, 1, 4'hF, 10'd40, 32'hA5A50000 | 32'($urandom_range(0, 65535)), 0);
      else if (i == 6) drive(1, 0, 4'hF, 10'd0, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0, 0);
      else             drive(1, 0, 4'hF, 10'd0, 32'h0, 1, 0, 4'hF, 10'd40, 32'h0, 0);
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL lock_rmw[%0d]: got %h model %h", i, got, want); end
      n_checks++;
      if ({bus.core_gnt, bus.dbg_gnt} !== ((i == 4 || i == 5) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL lock_rmw_gnt[%0d]: core/dbg gnt %b", i, {bus.core_gnt, bus.dbg_gnt});
      end
      adv();
    end
    idle();
    adv();
  endtask

  task automatic test_forced_release();
    logic [69:0] got, want;
    for (int i = 0; i < 26; i++) begin
      drive(1, 0, 4'hF, 10'd0, 32'h0, 1, 0, 4'hF, 10'd44, 32'h0, 1);
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL forced[%0d]: got %h model %h", i, got, want); end
      if (i <= 20) begin
        n_checks++;
        if ({bus.core_gnt, bus.dbg_gnt} !== ((i >= 4 && i < 20) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL forced_gnt[%0d]: core/dbg gnt %b", i, {bus.core_gnt, bus.dbg_gnt});
        end
      end
`ifdef DMEM_ARB_PERF_EN
      if (i == 21) begin
        n_checks++;
        if (perf_forced_release_cnt !== 16'd1) begin
          n_fail++; $display("FAIL perf_forced: got %0d required 1", perf_forced_release_cnt);
        end
      end
`endif
      adv();
    end
    idle();
    adv();
  endtask

  task automatic test_read_order();
    logic [69:0] got, want;
    logic [31:0] v0 = $urandom;
    logic [31:0] v4 = ~v0;
    drive(1, 1, 4'hF, 10'd0, v0, 0, 0, 4'h0, 10'd0, 32'h0, 0); adv();
    drive(1, 1, 4'hF, 10'd4, v4, 0, 0, 4'h0, 10'd0, 32'h0, 0); adv();
    for (int i = 0; i < 7; i++) begin
      drive(i <= 5, 0, 4'hF, 10'd0, 32'h0, i <= 4, 0, 4'hF, 10'd4, 32'h0, 0);
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL read_order[%0d]: got %h model %h", i, got, want); end
      if (i == 5) begin
        n_checks++;
        if ({bus.dbg_rvalid, bus.core_rvalid, bus.dbg_rdata} !== {2'b10, v4}) begin
          n_fail++; $display("FAIL read_order_dbg: dbg/core rvalid %b%b rdata %h required 10 %h", bus.dbg_rvalid, bus.core_rvalid, bus.dbg_rdata, v4);
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({bus.core_rvalid, bus.dbg_rvalid, bus.core_rdata} !== {2'b10, v0}) begin
          n_fail++; $display("FAIL read_order_core: core/dbg rvalid %b%b rdata %h required 10 %h", bus.core_rvalid, bus.dbg_rvalid, bus.core_rdata, v0);
        end
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [69:0] got, want;
    logic cr = 0, cw = 0, dr = 0, dw = 0, dl = 0;
    logic [3:0] cbe = '0, dbe = '0;
    logic [9:0] ca = '0, da = '0;
    logic [31:0] cd = '0, dd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cr && $urandom_range(0, 9) < 6) begin
        cr = 1; cw = 1'($urandom_range(0, 1)); cbe = 4'($urandom_range(1, 15));
        ca = 10'($urandom_range(0, 15) * 4); cd = $urandom;
      end
      if (!dr) begin
        dl = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) < 5) begin
          dr = 1; dw = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(1, 15));
          da = 10'($urandom_range(0, 15) * 4); dd = $urandom;
        end
      end
      drive(cr, cw, cbe, ca, cd, dr, dw, dbe, da, dd, dl);
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL random[%0d]: got %h model %h", i, got, want); end
      if (want[69]) cr = 0;
      if (want[68]) dr = 0;
      adv();
    end
    idle();
    adv();
`ifdef DMEM_ARB_PERF_EN
    @(negedge clock);
    n_checks++;
    if ({perf_core_stall_cnt, perf_dbg_grant_cnt, perf_forced_release_cnt} !== {32'(m_stall), 32'(m_dgnt), 16'(m_forced)}) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d/%0d model %0d/%0d/%0d", perf_core_stall_cnt,
                         perf_dbg_grant_cnt, perf_forced_release_cnt, m_stall, m_dgnt, m_forced);
    end
    adv();
`endif
  endtask

  task automatic test_reset_mid_read();
    logic [69:0] got, want;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, 0, 4'h0, 10'd0, 32'h0, 1, 0, 4'hF, 10'd8, 32'h0, 1);
        1: drive(1, 0, 4'hF, 10'd0, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0, 1);
        2: begin reset = 1'b0; drive(1, 0, 4'hF, 10'd4, 32'h0, 1, 0, 4'hF, 10'd8, 32'h0, 1); end
        3: begin reset = 1'b1; drive(1, 0, 4'hF, 10'd0, 32'h0, 1, 0, 4'hF, 10'd8, 32'h0, 0); end
        default: idle();
      endcase
      sample(got, want);
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid[%0d]: got %h model %h", i, got, want); end
      n_checks++;
      if (i == 0 && bus.dbg_gnt !== 1'b1) begin
        n_fail++; $display("FAIL reset_mid_lock: dbg_gnt %b required 1", bus.dbg_gnt);
      end else if (i == 1 && bus.core_gnt !== 1'b1) begin
        n_fail++; $display("FAIL reset_mid_lw: core_gnt %b required 1", bus.core_gnt);
      end else if (i == 2 && {bus.core_rvalid, bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.mem_en} !== 5'b0) begin
        n_fail++; $display("FAIL reset_mid_hold: rvalid/gnts/stall/en %b required 00000",
                           {bus.core_rvalid, bus.core_gnt, bus.dbg_gnt, bus.core_stall, bus.mem_en});
      end else if (i == 3 && {bus.core_gnt, bus.dbg_gnt, bus.core_rvalid} !== 3'b100) begin
        n_fail++; $display("FAIL reset_mid_norm: core_gnt/dbg_gnt/rvalid %b required 100",
                           {bus.core_gnt, bus.dbg_gnt, bus.core_rvalid});
      end
      adv();
    end
  endtask

  initial begin
    bus.mem_rdata = '0;
    idle();
    adv();
    test_reset();
    test_core_only();
    test_contention();
    test_lock_rmw();
    test_forced_release();
    test_read_order();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
